pipelined_adder: RTL and testbench

- Synchronous, pipelined unsigned adder: c = a + b, with the carry-out kept as the MSB of c.
- Operands split into CHUNK-bit slices; the carry ripples one slice per clock stage.
- Throughput is one result per cycle; a valid bit travels alongside the data.
- Sits in the datapath wherever a registered wide add is needed without a long combinational carry chain.

---
 rtl/pipelined_adder_pkg.sv | 12 +
 rtl/adder_slice.sv | 37 +++
 rtl/pipelined_adder.sv | 114 +++++++++++
 tb/tb_pipelined_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and helpers for the pipelined adder: operand/slice widths
// and the stage-count function that also defines the pipeline latency.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH = 32'sd16;
    localparam int DEF_CHUNK = 32'sd8;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One CHUNK-bit slice of the pipelined adder: registers slice sum and carry-out,
// updating only when a valid token occupies this stage.
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] sum_r;
    logic             cout_r;

    // Slice sum/carry register; bubbles leave the previous result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {CHUNK{1'b0}};
            cout_r <= 1'b0;
        end else if (en) begin
            {cout_r, sum_r} <= {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder c = a + b: the carry ripples one CHUNK-bit slice per
// clock, with a valid bit, operand residues and finished low sums moving alongside.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH:0]   c
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
        $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end

    // valid_r[k] marks that stage k's registers hold a live token.
    logic [STAGES-1:0] valid_r;

    // Valid shift register; bubbles travel through as zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {STAGES{1'b0}};
        end else begin
            valid_r[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = WIDTH - k * CHUNK;

        logic                   en_s;
        logic [IN_W-1:0]        src_a_s;
        logic [IN_W-1:0]        src_b_s;
        logic                   cin_s;
        logic [CHUNK-1:0]       sum_s;
        logic                   cout_s;
        logic [(k+1)*CHUNK-1:0] acc_s;

        if (k == 0) begin : g_head
            assign en_s    = in_valid;
            assign src_a_s = a;
            assign src_b_s = b;
            assign cin_s   = 1'b0;
            assign acc_s   = sum_s;
        end else begin : g_tail
            logic [k*CHUNK-1:0] low_r;

            assign en_s    = valid_r[k-1];
            assign src_a_s = g_stage[k-1].g_res.res_a_r;
            assign src_b_s = g_stage[k-1].g_res.res_b_r;
            assign cin_s   = g_stage[k-1].cout_s;
            assign acc_s   = {sum_s, low_r};

            // Already-finished lower slices of the sum, delayed with their token.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    low_r <= {(k*CHUNK){1'b0}};
                end else if (en_s) begin
                    low_r <= g_stage[k-1].acc_s;
                end else begin
                    low_r <= low_r;
                end
            end
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en_s),
            .a     (src_a_s[CHUNK-1:0]),
            .b     (src_b_s[CHUNK-1:0]),
            .cin   (cin_s),
            .sum   (sum_s),
            .cout  (cout_s)
        );

        if (k < STAGES - 1) begin : g_res
            logic [IN_W-CHUNK-1:0] res_a_r;
            logic [IN_W-CHUNK-1:0] res_b_r;

            // Operand slices not yet consumed, carried to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_a_r <= {(IN_W-CHUNK){1'b0}};
                    res_b_r <= {(IN_W-CHUNK){1'b0}};
                end else if (en_s) begin
                    res_a_r <= src_a_s[IN_W-1:CHUNK];
                    res_b_r <= src_b_s[IN_W-1:CHUNK];
                end else begin
                    res_a_r <= res_a_r;
                    res_b_r <= res_b_r;
                end
            end
        end
    end

    // The last stage's registers already form the complete, held result.
    assign out_valid = valid_r[STAGES-1];
    assign c         = {g_stage[STAGES-1].cout_s, g_stage[STAGES-1].acc_s};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised self-checking bench for pipelined_adder
// (default 16/8 two-stage instance plus a single-stage 8/8 instance).
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [16:0] c;

    logic        in_valid1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        out_valid1;
    logic [8:0]  c1;

    int checks = 0;
    int errors = 0;

    pipelined_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .c         (c)
    );

    pipelined_adder #(
        .WIDTH (8),
        .CHUNK (8)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .c         (c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
    endtask

    task automatic chk(input string tag, input logic exp_v, input logic [16:0] exp_c);
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_v);
        end
        checks++;
        assert (c === exp_c) else begin
            errors++;
            $error("FAIL %s c: got %h expected %h", tag, c, exp_c);
        end
    endtask

    task automatic chk1(input string tag, input logic exp_v, input logic [8:0] exp_c);
        checks++;
        assert (out_valid1 === exp_v) else begin
            errors++;
            $error("FAIL %s out_valid1: got %b expected %b", tag, out_valid1, exp_v);
        end
        checks++;
        assert (c1 === exp_c) else begin
            errors++;
            $error("FAIL %s c1: got %h expected %h", tag, c1, exp_c);
        end
    endtask

    logic [16:0] exp_q[$];
    logic [16:0] exp_v;
    int          accepted;
    int          pulses;
    int          iter;
    logic        v_r;
    logic [15:0] a_r;
    logic [15:0] b_r;

    initial begin
        rst_n     = 1'b0;
        in_valid1 = 1'b0;
        a1        = 8'd0;
        b1        = 8'd0;
        drive(1'b1, 16'd5, 16'd7);

        // Reset held with valid input: nothing may come out.
        cyc(); chk("rst0", 1'b0, 17'd0);
        cyc(); chk("rst1", 1'b0, 17'd0);
        cyc(); chk("rst2", 1'b0, 17'd0);
        chk1("rst_single", 1'b0, 9'd0);

        rst_n = 1'b1;
        cyc(); chk("lat_first", 1'b0, 17'd0);
        drive(1'b1, 16'h00FF, 16'h0001);
        cyc(); chk("lat_5p7", 1'b1, 17'd12);
        drive(1'b1, 16'h00FF, 16'hFF01);
        cyc(); chk("carry_256", 1'b1, 17'h00100);
        drive(1'b1, 16'hFFFF, 16'hFFFF);
        cyc(); chk("carry_full", 1'b1, 17'h10000);
        drive(1'b1, 16'h0000, 16'h0000);
        cyc(); chk("max", 1'b1, 17'h1FFFE);
        drive(1'b0, 16'h1234, 16'h0001);
        cyc(); chk("zero", 1'b1, 17'd0);
        cyc(); chk("idle_ops_ignored", 1'b0, 17'd0);

        // Streaming with a bubble.
        drive(1'b1, 16'd10, 16'd20);
        cyc(); chk("strm0", 1'b0, 17'd0);
        drive(1'b1, 16'd99, 16'd1);
        cyc(); chk("strm_30", 1'b1, 17'd30);
        drive(1'b0, 16'd77, 16'd88);
        cyc(); chk("strm_100", 1'b1, 17'd100);
        drive(1'b1, 16'd1234, 16'd4321);
        cyc(); chk("strm_bubble", 1'b0, 17'd100);
        drive(1'b0, 16'd0, 16'd0);
        cyc(); chk("strm_5555", 1'b1, 17'd5555);
        cyc(); chk("strm_hold", 1'b0, 17'd5555);

        // Reset mid-flight.
        drive(1'b1, 16'd1, 16'd2);
        cyc(); chk("mf0", 1'b0, 17'd5555);
        drive(1'b1, 16'd3, 16'd4);
        cyc(); chk("mf_3", 1'b1, 17'd3);
        drive(1'b1, 16'd5, 16'd6);
        cyc(); chk("mf_7", 1'b1, 17'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mf_async", 1'b0, 17'd0);
        drive(1'b0, 16'd0, 16'd0);
        cyc(); chk("mf_held", 1'b0, 17'd0);
        rst_n = 1'b1;
        cyc(); chk("mf_rel0", 1'b0, 17'd0);
        cyc(); chk("mf_rel1", 1'b0, 17'd0);
        cyc(); chk("mf_rel2", 1'b0, 17'd0);

        // Single-stage instance: latency 1, holds on bubble.
        in_valid1 = 1'b1;
        a1        = 8'd200;
        b1        = 8'd100;
        cyc(); chk1("single_300", 1'b1, 9'd300);
        in_valid1 = 1'b0;
        a1        = 8'd1;
        b1        = 8'd1;
        cyc(); chk1("single_hold", 1'b0, 9'd300);

        // Random scoreboard.
        accepted = 0;
        pulses   = 0;
        iter     = 0;
        while (((accepted < 1000) || (exp_q.size() != 0)) && (iter < 5000)) begin
            v_r = (accepted < 1000) && ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                a_r = 16'($urandom_range(0, 99));
                b_r = 16'($urandom_range(0, 99));
            end else begin
                a_r = 16'($urandom);
                b_r = 16'($urandom);
            end
            drive(v_r, a_r, b_r);
            cyc();
            if (v_r) begin
                exp_q.push_back({1'b0, a_r} + {1'b0, b_r});
                accepted++;
            end
            if (out_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL rnd_extra: got out_valid with c=%h expected no output", c);
                end else begin
                    exp_v = exp_q.pop_front();
                    checks++;
                    assert (c === exp_v) else begin
                        errors++;
                        $error("FAIL rnd_sum: got %h expected %h", c, exp_v);
                    end
                end
            end
            iter++;
        end
        drive(1'b0, 16'd0, 16'd0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL rnd_drain: got %0d outstanding expected 0", exp_q.size());
        end
        checks++;
        assert (pulses == accepted) else begin
            errors++;
            $error("FAIL rnd_count: got %0d pulses expected %0d", pulses, accepted);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
